execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  EX stage: consumer of the ID/EX register outputs. Forwards operands, runs the RV64I ALU,
//  resolves branches/jumps (redirect), and executes MUL on an iterative multiplier with stall handshake.
//  Drives the registered EX/MEM pipeline register consumed by the memory stage.
// PARAMETERS
//  MUL_BITS  4  multiplier bits retired per iteration; must divide 64; N_ITER = 64/MUL_BITS
// PORTS
//  clk                     in  1   clock, all state on rising edge
//  rst                     in  1   synchronous, active-low reset (0 = reset)
//  pc_in, rs1_data_in, rs2_data_in, imm_in, branch_target_in  in 64 each  from ID/EX
//  rs1_addr_in, rs2_addr_in, rd_addr_in  in 5 each  register addresses from ID/EX
//  funct3_in / funct7_in / opcode_in     in 3/7/7  instruction fields from ID/EX
//  mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in, alu_src_in, branch_in, jump_in  in 1 each
//  wb_reg_write, wb_rd_addr, wb_data     in 1/5/64  MEM/WB forwarding source
//  mem_stall               in  1   memory stage not accepting; hold EX/MEM
//  ex_busy                 out 1   multiplier occupying EX; hazard unit stalls IF/ID and ID/EX
//  redirect, redirect_pc   out 1/64  taken branch/jump; flush IF/ID, ID/EX; load PC
//  exm_alu_result, exm_store_data  out 64 each  EX/MEM result / forwarded rs2
//  exm_rd_addr, exm_funct3 out 5/3 EX/MEM fields
//  exm_mem_read, exm_mem_write, exm_reg_write, exm_mem_to_reg  out 1 each  EX/MEM controls
// BEHAVIOUR
//  Reset (rst=0 at edge): every exm_* = 0, FSM=IDLE, counter/accumulator = 0; ex_busy/redirect = 0.
//  Bubble: opcode_in==0 -> no redirect, no mul start, EX/MEM loads all-zero controls.
//  Forwarding per operand: EX/MEM (exm_reg_write, exm_rd_addr==rsX, !exm_mem_read) beats MEM/WB;
//   x0 never forwarded; load-use is the hazard unit's job.
//  Operand B = alu_src_in ? imm_in : fwd rs2. 64-bit arithmetic, wrap mod 2^64.
//  ALU: ADD/SUB(funct7[5], R-type only), SLL/SRL/SRA shamt[5:0], SLT, SLTU, XOR, OR, AND;
//   LUI -> imm; AUIPC -> pc+imm; JAL/JALR -> pc+4; load/store -> rs1+imm.
//  Branch (funct3): BEQ BNE BLT BGE BLTU BGEU on forwarded operands.
//  redirect = (taken branch | jump) & !mem_stall & !ex_busy, combinational;
//   redirect_pc = JALR ? (rs1+imm)&~1 : branch_target_in.
//  EX/MEM: mem_stall=1 -> hold; else load ALU result/controls, or bubble while ex_busy=1.
//  MUL (opcode 0110011, funct7 0000001, funct3 000), low 64 bits of product:
//   IDLE: MUL present -> ex_busy=1, latch fwd operands, acc=0, cnt=0 -> ITER.
//   ITER: ex_busy=1; acc += (a * b[MUL_BITS-1:0]) << cnt*MUL_BITS; b>>=MUL_BITS;
//    cnt==N_ITER-1 -> DONE.
//   DONE: ex_busy=0; exm_alu_result<=acc with MUL controls; ->IDLE when !mem_stall, else stay.
//   EX occupancy N_ITER+2 cycles (16+2=18 at default); ex_busy high N_ITER+1 cycles.
//   Other M-ext funct3: treated as ALU op result 0 (unsupported, no trap).
//  Reset mid-multiply: FSM->IDLE, ex_busy=0 same edge, partial result discarded.
// TESTING
//  ADDI x1,x0,5 then ADD x2,x1,x1 back-to-back -> EX/MEM forward, exm_alu_result=10.
//  rs1 matches both EX/MEM (7) and MEM/WB (9) -> 7 used; rs1=x0 with wb_rd_addr=0 -> operand 0.
//  BEQ equal, pc=0x100, target 0x120 -> redirect=1, redirect_pc=0x120 one cycle; mem_stall=1 -> redirect=0.
//  JALR rs1=0x1001, imm=2, pc=0x40 -> redirect_pc=0x1002, exm_alu_result=0x44.
//  MUL 0xFFFF_FFFF_FFFF_FFFF*3 -> ex_busy high 17 cycles, then exm_alu_result=0xFFFF_FFFF_FFFF_FFFD.
//  rst=0 at ITER cnt=5 -> next cycle ex_busy=0, exm_*=0; new MUL 6*7 -> 42.

Source files
------------

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage
//  Description : RV64I execute stage. Forwards operands from EX/MEM and MEM/WB,
//                evaluates the ALU, resolves branches and jumps into a
//                redirect, and runs MUL on an iterative radix-2^MUL_BITS
//                multiplier that stalls the front end through ex_busy.
//                Drives the registered EX/MEM pipeline register.
//  Ports       : clk, rst (sync, active-low)
//                ID/EX   : pc/rs1/rs2/imm/branch_target data, rs1/rs2/rd
//                          addresses, funct3/funct7/opcode, control bits
//                MEM/WB  : wb_reg_write, wb_rd_addr, wb_data (forward source)
//                mem_stall : memory stage back-pressure, EX/MEM holds
//                ex_busy   : multiplier occupying EX
//                redirect, redirect_pc : taken branch / jump
//                exm_*     : EX/MEM pipeline register outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_stage #(
    parameter int MUL_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pc_in,
    input  logic [63:0] rs1_data_in,
    input  logic [63:0] rs2_data_in,
    input  logic [63:0] imm_in,
    input  logic [63:0] branch_target_in,
    input  logic [4:0]  rs1_addr_in,
    input  logic [4:0]  rs2_addr_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [2:0]  funct3_in,
    input  logic [6:0]  funct7_in,
    input  logic [6:0]  opcode_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    input  logic        alu_src_in,
    input  logic        branch_in,
    input  logic        jump_in,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd_addr,
    input  logic [63:0] wb_data,
    input  logic        mem_stall,
    output logic        ex_busy,
    output logic        redirect,
    output logic [63:0] redirect_pc,
    output logic [63:0] exm_alu_result,
    output logic [63:0] exm_store_data,
    output logic [4:0]  exm_rd_addr,
    output logic [2:0]  exm_funct3,
    output logic        exm_mem_read,
    output logic        exm_mem_write,
    output logic        exm_reg_write,
    output logic        exm_mem_to_reg
);

    localparam int c_N_ITER = 64 / MUL_BITS;
    localparam int c_CNT_W  = (c_N_ITER > 1) ? $clog2(c_N_ITER) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_N_ITER - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ITER = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_F7_MULDIV = 7'b0000001;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [63:0]        r_acc;
    logic [63:0]        r_mul_a;
    logic [63:0]        r_mul_b;
    logic [4:0]         r_mul_rd;
    logic [2:0]         r_mul_f3;
    logic               r_mul_rw;

    logic        w_valid;
    logic        w_is_mul;
    logic [63:0] w_rs1_fwd;
    logic [63:0] w_rs2_fwd;
    logic [63:0] w_op_b;
    logic [5:0]  w_shamt;
    logic [63:0] w_alu_result;
    logic        w_taken;
    logic [63:0] w_pp;

    // opcode 0 is the bubble encoding inserted by the hazard unit
    assign w_valid  = (opcode_in != 7'd0);
    assign w_is_mul = (opcode_in == c_OP_REG) && (funct7_in == c_F7_MULDIV) &&
                      (funct3_in == 3'b000);

    // Youngest producer wins; a load in EX/MEM has no data yet, so it is
    // skipped and the hazard unit is responsible for the load-use stall.
    always_comb begin
        w_rs1_fwd = rs1_data_in;
        if (rs1_addr_in != 5'd0) begin
            if (exm_reg_write && !exm_mem_read && (exm_rd_addr == rs1_addr_in))
                w_rs1_fwd = exm_alu_result;
            else if (wb_reg_write && (wb_rd_addr == rs1_addr_in))
                w_rs1_fwd = wb_data;
        end
        w_rs2_fwd = rs2_data_in;
        if (rs2_addr_in != 5'd0) begin
            if (exm_reg_write && !exm_mem_read && (exm_rd_addr == rs2_addr_in))
                w_rs2_fwd = exm_alu_result;
            else if (wb_reg_write && (wb_rd_addr == rs2_addr_in))
                w_rs2_fwd = wb_data;
        end
    end

    assign w_op_b  = alu_src_in ? imm_in : w_rs2_fwd;
    assign w_shamt = w_op_b[5:0];

    always_comb begin
        w_alu_result = 64'd0;
        case (opcode_in)
            c_OP_LUI:               w_alu_result = imm_in;
            c_OP_AUIPC:             w_alu_result = pc_in + imm_in;
            c_OP_JAL, c_OP_JALR:    w_alu_result = pc_in + 64'd4;
            c_OP_LOAD, c_OP_STORE:  w_alu_result = w_rs1_fwd + imm_in;
            c_OP_IMM, c_OP_REG: begin
                // M-extension encodings other than MUL produce 0
                if (!((opcode_in == c_OP_REG) && (funct7_in == c_F7_MULDIV))) begin
                    case (funct3_in)
                        3'b000: w_alu_result = ((opcode_in == c_OP_REG) && funct7_in[5]) ?
                                               (w_rs1_fwd - w_op_b) : (w_rs1_fwd + w_op_b);
                        3'b001: w_alu_result = w_rs1_fwd << w_shamt;
                        3'b010: w_alu_result = {63'd0, ($signed(w_rs1_fwd) < $signed(w_op_b))};
                        3'b011: w_alu_result = {63'd0, (w_rs1_fwd < w_op_b)};
                        3'b100: w_alu_result = w_rs1_fwd ^ w_op_b;
                        3'b101: w_alu_result = funct7_in[5] ? ($signed(w_rs1_fwd) >>> w_shamt)
                                                            : (w_rs1_fwd >> w_shamt);
                        3'b110: w_alu_result = w_rs1_fwd | w_op_b;
                        default: w_alu_result = w_rs1_fwd & w_op_b;
                    endcase
                end
            end
            default: w_alu_result = 64'd0;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (funct3_in)
            3'b000: w_taken = (w_rs1_fwd == w_rs2_fwd);
            3'b001: w_taken = (w_rs1_fwd != w_rs2_fwd);
            3'b100: w_taken = ($signed(w_rs1_fwd) <  $signed(w_rs2_fwd));
            3'b101: w_taken = ($signed(w_rs1_fwd) >= $signed(w_rs2_fwd));
            3'b110: w_taken = (w_rs1_fwd <  w_rs2_fwd);
            3'b111: w_taken = (w_rs1_fwd >= w_rs2_fwd);
            default: w_taken = 1'b0;
        endcase
    end

    // Busy is raised in the same cycle the MUL is first seen so the front end
    // freezes immediately, and drops in DONE so the MUL can leave ID/EX.
    assign ex_busy = ((r_state == c_IDLE) && w_is_mul) || (r_state == c_ITER);

    assign redirect = w_valid && ((branch_in && w_taken) || jump_in) &&
                      !mem_stall && !ex_busy;
    assign redirect_pc = (opcode_in == c_OP_JALR) ? ((w_rs1_fwd + imm_in) & ~64'd1)
                                                  : branch_target_in;

    // r_mul_a is pre-shifted each step, so a*digit already carries the
    // cnt*MUL_BITS weight of the current digit.
    assign w_pp = r_mul_a * 64'(r_mul_b[MUL_BITS-1:0]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_acc    <= 64'd0;
            r_mul_a  <= 64'd0;
            r_mul_b  <= 64'd0;
            r_mul_rd <= 5'd0;
            r_mul_f3 <= 3'd0;
            r_mul_rw <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_is_mul) begin
                        r_mul_a  <= w_rs1_fwd;
                        r_mul_b  <= w_rs2_fwd;
                        r_acc    <= 64'd0;
                        r_cnt    <= '0;
                        r_mul_rd <= rd_addr_in;
                        r_mul_f3 <= funct3_in;
                        r_mul_rw <= reg_write_in;
                        r_state  <= c_ITER;
                    end
                end
                c_ITER: begin
                    r_acc   <= r_acc + w_pp;
                    r_mul_a <= r_mul_a << MUL_BITS;
                    r_mul_b <= r_mul_b >> MUL_BITS;
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_CNT_LAST)
                        r_state <= c_DONE;
                end
                c_DONE: begin
                    if (!mem_stall)
                        r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            exm_alu_result <= 64'd0;
            exm_store_data <= 64'd0;
            exm_rd_addr    <= 5'd0;
            exm_funct3     <= 3'd0;
            exm_mem_read   <= 1'b0;
            exm_mem_write  <= 1'b0;
            exm_reg_write  <= 1'b0;
            exm_mem_to_reg <= 1'b0;
        end else if (!mem_stall) begin
            if (r_state == c_DONE) begin
                exm_alu_result <= r_acc;
                exm_store_data <= 64'd0;
                exm_rd_addr    <= r_mul_rd;
                exm_funct3     <= r_mul_f3;
                exm_mem_read   <= 1'b0;
                exm_mem_write  <= 1'b0;
                exm_reg_write  <= r_mul_rw;
                exm_mem_to_reg <= 1'b0;
            end else if (ex_busy || !w_valid) begin
                exm_alu_result <= 64'd0;
                exm_store_data <= 64'd0;
                exm_rd_addr    <= 5'd0;
                exm_funct3     <= 3'd0;
                exm_mem_read   <= 1'b0;
                exm_mem_write  <= 1'b0;
                exm_reg_write  <= 1'b0;
                exm_mem_to_reg <= 1'b0;
            end else begin
                exm_alu_result <= w_alu_result;
                exm_store_data <= w_rs2_fwd;
                exm_rd_addr    <= rd_addr_in;
                exm_funct3     <= funct3_in;
                exm_mem_read   <= mem_read_in;
                exm_mem_write  <= mem_write_in;
                exm_reg_write  <= reg_write_in;
                exm_mem_to_reg <= mem_to_reg_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_execute_stage
//  Description : Self-checking bench for execute_stage: directed forwarding,
//                branch, JALR and multiplier scenarios plus randomized ALU
//                traffic checked against an instruction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

    localparam int MUL_BITS = 4;
    localparam int c_BUSY_CYCLES = 64 / MUL_BITS + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_in, rs1_data_in, rs2_data_in, imm_in, branch_target_in;
    logic [4:0]  rs1_addr_in, rs2_addr_in, rd_addr_in;
    logic [2:0]  funct3_in;
    logic [6:0]  funct7_in, opcode_in;
    logic        mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
    logic        alu_src_in, branch_in, jump_in;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [63:0] wb_data;
    logic        mem_stall;
    logic        ex_busy, redirect;
    logic [63:0] redirect_pc, exm_alu_result, exm_store_data;
    logic [4:0]  exm_rd_addr;
    logic [2:0]  exm_funct3;
    logic        exm_mem_read, exm_mem_write, exm_reg_write, exm_mem_to_reg;

    int n_cmp = 0;
    int n_err = 0;

    // expected EX/MEM contents
    logic [63:0] m_res, m_sd;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic        m_mr, m_mw, m_rw, m_mtr;
    logic        m_res_care, m_data_care;

    execute_stage #(.MUL_BITS(MUL_BITS)) dut (
        .clk(clk), .rst(rst),
        .pc_in(pc_in), .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
        .imm_in(imm_in), .branch_target_in(branch_target_in),
        .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in), .rd_addr_in(rd_addr_in),
        .funct3_in(funct3_in), .funct7_in(funct7_in), .opcode_in(opcode_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .alu_src_in(alu_src_in), .branch_in(branch_in), .jump_in(jump_in),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .mem_stall(mem_stall), .ex_busy(ex_busy),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .exm_alu_result(exm_alu_result), .exm_store_data(exm_store_data),
        .exm_rd_addr(exm_rd_addr), .exm_funct3(exm_funct3),
        .exm_mem_read(exm_mem_read), .exm_mem_write(exm_mem_write),
        .exm_reg_write(exm_reg_write), .exm_mem_to_reg(exm_mem_to_reg)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // architectural view of an operand: newest in-flight writer of the register
    function automatic logic [63:0] fwd(input logic [4:0] r, input logic [63:0] rf_val);
        if (r == 5'd0) return rf_val;
        if (m_rw && !m_mr && m_rd == r) return m_res;
        if (wb_reg_write && wb_rd_addr == r) return wb_data;
        return rf_val;
    endfunction

    task automatic clear_instr();
        pc_in = '0; rs1_data_in = '0; rs2_data_in = '0; imm_in = '0; branch_target_in = '0;
        rs1_addr_in = '0; rs2_addr_in = '0; rd_addr_in = '0;
        funct3_in = '0; funct7_in = '0; opcode_in = '0;
        mem_read_in = 0; mem_write_in = 0; reg_write_in = 0; mem_to_reg_in = 0;
        alu_src_in = 0; branch_in = 0; jump_in = 0;
        wb_reg_write = 0; wb_rd_addr = '0; wb_data = '0; mem_stall = 0;
    endtask

    task automatic model_bubble();
        m_res = '0; m_sd = '0; m_rd = '0; m_f3 = '0;
        m_mr = 0; m_mw = 0; m_rw = 0; m_mtr = 0;
        m_res_care = 0; m_data_care = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_instr();
        opcode_in = 7'b0010011; reg_write_in = 1; rd_addr_in = 5'd3; imm_in = 64'd77; alu_src_in = 1;
        @(posedge clk); #1;
        n_cmp++;
        if ({exm_alu_result, exm_store_data, exm_rd_addr, exm_funct3, exm_mem_read,
             exm_mem_write, exm_reg_write, exm_mem_to_reg} !== '0) begin
            n_err++; $display("FAIL reset_exm: got res=%h rw=%b rd=%0d, want all zero",
                              exm_alu_result, exm_reg_write, exm_rd_addr);
        end
        clear_instr();
        #1;
        n_cmp++;
        if (ex_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", ex_busy); end
        n_cmp++;
        if (redirect !== 1'b0) begin n_err++; $display("FAIL reset_redirect: got %b want 0", redirect); end
        @(posedge clk); #1;
        rst = 1'b1;
        model_bubble();
    endtask

    task automatic test_forwarding();
        clear_instr(); @(posedge clk); #1;
        // ADDI x1,x0,5
        clear_instr(); opcode_in = 7'b0010011; rd_addr_in = 5'd1; imm_in = 64'd5;
        alu_src_in = 1; reg_write_in = 1;
        @(posedge clk); #1;
        n_cmp++;
        if (exm_alu_result !== 64'd5) begin n_err++; $display("FAIL addi: got %h want 5", exm_alu_result); end
        // ADD x2,x1,x1 with stale register file value
        clear_instr(); opcode_in = 7'b0110011; rs1_addr_in = 5'd1; rs2_addr_in = 5'd1;
        rd_addr_in = 5'd2; reg_write_in = 1;
        @(posedge clk); #1;
        n_cmp++;
        if (exm_alu_result !== 64'd10) begin n_err++; $display("FAIL fwd_exm: got %h want 10", exm_alu_result); end
        // ADDI x3,x0,7 then ADD x4,x3,x0 with MEM/WB also writing x3=9
        clear_instr(); opcode_in = 7'b0010011; rd_addr_in = 5'd3; imm_in = 64'd7;
        alu_src_in = 1; reg_write_in = 1;
        @(posedge clk); #1;
        clear_instr(); opcode_in = 7'b0110011; rs1_addr_in = 5'd3; rs1_data_in = 64'd1;
        rd_addr_in = 5'd4; reg_write_in = 1;
        wb_reg_write = 1; wb_rd_addr = 5'd3; wb_data = 64'd9;
        @(posedge clk); #1;
        n_cmp++;
        if (exm_alu_result !== 64'd7) begin n_err++; $display("FAIL fwd_priority: got %h want 7", exm_alu_result); end
        // x0 never forwarded
        clear_instr(); opcode_in = 7'b0110011; rd_addr_in = 5'd5; reg_write_in = 1;
        wb_reg_write = 1; wb_rd_addr = 5'd0; wb_data = 64'hdead;
        @(posedge clk); #1;
        n_cmp++;
        if (exm_alu_result !== 64'd0) begin n_err++; $display("FAIL fwd_x0: got %h want 0", exm_alu_result); end
        // MEM/WB-only forward
        clear_instr(); opcode_in = 7'b0110011; rs1_addr_in = 5'd7; rs1_data_in = 64'd1;
        rd_addr_in = 5'd6; reg_write_in = 1;
        wb_reg_write = 1; wb_rd_addr = 5'd7; wb_data = 64'd9;
        @(posedge clk); #1;
        n_cmp++;
        if (exm_alu_result !== 64'd9) begin n_err++; $display("FAIL fwd_wb: got %h want 9", exm_alu_result); end
        // load in EX/MEM is not a forwarding source
        clear_instr(); opcode_in = 7'b0000011; rd_addr_in = 5'd8; imm_in = 64'h100;
        alu_src_in = 1; reg_write_in = 1; mem_read_in = 1; mem_to_reg_in = 1;
        @(posedge clk); #1;
        n_cmp++;
        if ({exm_alu_result, exm_mem_read, exm_mem_to_reg} !== {64'h100, 2'b11}) begin
            n_err++; $display("FAIL load_addr: got %h mr=%b want 100 mr=1", exm_alu_result, exm_mem_read);
        end
        clear_instr(); opcode_in = 7'b0110011; rs1_addr_in = 5'd8; rs1_data_in = 64'd3;
        rd_addr_in = 5'd9; reg_write_in = 1;
        @(posedge clk); #1;
        n_cmp++;
        if (exm_alu_result !== 64'd3) begin n_err++; $display("FAIL no_fwd_load: got %h want 3", exm_alu_result); end
        // store data forwarded from x9
        clear_instr(); opcode_in = 7'b0100011; rs2_addr_in = 5'd9; imm_in = 64'd8;
        alu_src_in = 1; mem_write_in = 1; funct3_in = 3'b011;
        @(posedge clk); #1;
        n_cmp++;
        if ({exm_store_data, exm_alu_result, exm_mem_write, exm_reg_write} !== {64'd3, 64'd8, 2'b10}) begin
            n_err++; $display("FAIL store_fwd: got sd=%h addr=%h want sd=3 addr=8", exm_store_data, exm_alu_result);
        end
    endtask

    task automatic test_branch();
        clear_instr(); @(posedge clk); #1;
        clear_instr(); opcode_in = 7'b1100011; branch_in = 1; funct3_in = 3'b000;
        rs1_addr_in = 5'd10; rs2_addr_in = 5'd11; rs1_data_in = 64'h55; rs2_data_in = 64'h55;
        pc_in = 64'h100; branch_target_in = 64'h120;
        @(negedge clk);
        n_cmp++;
        if ({redirect, redirect_pc} !== {1'b1, 64'h120}) begin
            n_err++; $display("FAIL beq_taken: got redirect=%b pc=%h want 1 120", redirect, redirect_pc);
        end
        mem_stall = 1; #1;
        n_cmp++;
        if (redirect !== 1'b0) begin n_err++; $display("FAIL beq_stall: got %b want 0", redirect); end
        mem_stall = 0;
        @(posedge clk); #1;
        clear_instr(); #1;
        n_cmp++;
        if (redirect !== 1'b0) begin n_err++; $display("FAIL beq_one_cycle: got %b want 0", redirect); end
        // BNE on equal operands: not taken
        opcode_in = 7'b1100011; branch_in = 1; funct3_in = 3'b001;
        rs1_addr_in = 5'd10; rs2_addr_in = 5'd11; rs1_data_in = 64'h55; rs2_data_in = 64'h55;
        branch_target_in = 64'h200; #1;
        n_cmp++;
        if (redirect !== 1'b0) begin n_err++; $display("FAIL bne_equal: got %b want 0", redirect); end
        // 1 vs all-ones: unsigned less, signed greater
        funct3_in = 3'b110; rs1_data_in = 64'd1; rs2_data_in = '1; #1;
        n_cmp++;
        if (redirect !== 1'b1) begin n_err++; $display("FAIL bltu: got %b want 1", redirect); end
        funct3_in = 3'b100; #1;
        n_cmp++;
        if (redirect !== 1'b0) begin n_err++; $display("FAIL blt: got %b want 0", redirect); end
        @(posedge clk); #1;
    endtask

    task automatic test_jalr();
        clear_instr(); @(posedge clk); #1;
        clear_instr(); opcode_in = 7'b1100111; jump_in = 1; alu_src_in = 1; reg_write_in = 1;
        rs1_addr_in = 5'd12; rs1_data_in = 64'h1001; imm_in = 64'd2; pc_in = 64'h40;
        rd_addr_in = 5'd1; branch_target_in = 64'h999;
        @(negedge clk);
        n_cmp++;
        if ({redirect, redirect_pc} !== {1'b1, 64'h1002}) begin
            n_err++; $display("FAIL jalr_target: got redirect=%b pc=%h want 1 1002", redirect, redirect_pc);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (exm_alu_result !== 64'h44) begin n_err++; $display("FAIL jalr_link: got %h want 44", exm_alu_result); end
    endtask

    task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd, input logic stall);
        int busy;
        logic [63:0] prod;
        prod = a * b;
        clear_instr(); @(posedge clk); #1;
        clear_instr(); opcode_in = 7'b0110011; funct7_in = 7'b0000001; funct3_in = 3'b000;
        rs1_addr_in = 5'd20; rs2_addr_in = 5'd21; rs1_data_in = a; rs2_data_in = b;
        rd_addr_in = rd; reg_write_in = 1;
        busy = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!ex_busy) break;
            busy++;
        end
        n_cmp++;
        if (busy != c_BUSY_CYCLES) begin
            n_err++; $display("FAIL mul_busy_len: got %0d cycles want %0d", busy, c_BUSY_CYCLES);
        end
        clear_instr();
        if (stall) begin
            mem_stall = 1;
            repeat (2) @(posedge clk);
            #1;
            n_cmp++;
            if ({exm_reg_write, ex_busy} !== 2'b00) begin
                n_err++; $display("FAIL mul_done_hold: got rw=%b busy=%b want 0 0", exm_reg_write, ex_busy);
            end
            mem_stall = 0;
        end
        @(posedge clk); #1;
        n_cmp++;
        if (exm_alu_result !== prod) begin
            n_err++; $display("FAIL mul_result: %h*%h got %h want %h", a, b, exm_alu_result, prod);
        end
        n_cmp++;
        if ({exm_rd_addr, exm_reg_write, exm_mem_read, exm_mem_write, ex_busy} !== {rd, 4'b1000}) begin
            n_err++; $display("FAIL mul_ctrl: got rd=%0d rw=%b busy=%b want rd=%0d rw=1 busy=0",
                              exm_rd_addr, exm_reg_write, ex_busy, rd);
        end
        model_bubble();
        m_res = prod; m_rd = rd; m_rw = 1; m_res_care = 1;
    endtask

    task automatic test_mul();
        run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd13, 1'b0);
    endtask

    task automatic test_mul_reset();
        clear_instr(); @(posedge clk); #1;
        clear_instr(); opcode_in = 7'b0110011; funct7_in = 7'b0000001;
        rs1_data_in = 64'h1234; rs2_data_in = 64'h5678; rd_addr_in = 5'd14; reg_write_in = 1;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0; clear_instr();
        @(posedge clk); #1;
        n_cmp++;
        if ({ex_busy, exm_reg_write, exm_alu_result} !== {2'b00, 64'd0}) begin
            n_err++; $display("FAIL mul_reset: got busy=%b rw=%b res=%h want 0 0 0",
                              ex_busy, exm_reg_write, exm_alu_result);
        end
        rst = 1'b1;
        model_bubble();
        run_mul(64'd6, 64'd7, 5'd15, 1'b0);
    endtask

    task automatic test_random_mul(input int n);
        for (int i = 0; i < n; i++)
            run_mul(rand64(), (i % 2 == 0) ? rand64() : 64'($urandom),
                    5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_random_alu(input int n);
        logic [63:0] a, r2, b, exp_res, exp_pc;
        logic        exp_redir, taken, res_care, is_bub;
        int          kind;
        for (int i = 0; i < n; i++) begin
            clear_instr();
            kind = int'($urandom_range(0, 10));
            rs1_addr_in = 5'($urandom_range(0, 7));
            rs2_addr_in = 5'($urandom_range(0, 7));
            rd_addr_in  = 5'($urandom_range(1, 7));
            rs1_data_in = rand64();
            rs2_data_in = ($urandom_range(0, 3) == 0) ? rs1_data_in : rand64();
            imm_in = ($urandom_range(0, 1) == 1) ? rand64() : 64'($urandom_range(0, 4095));
            pc_in = {32'd0, $urandom} & ~64'd3;
            branch_target_in = rand64();
            wb_reg_write = 1'($urandom_range(0, 1));
            wb_rd_addr = 5'($urandom_range(0, 7));
            wb_data = rand64();
            mem_stall = ($urandom_range(0, 7) == 0);
            funct3_in = 3'($urandom_range(0, 7));
            case (kind)
                0: begin
                    opcode_in = 7'b0110011; reg_write_in = 1;
                    funct7_in = ((funct3_in == 3'd0 || funct3_in == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                end
                1: begin
                    opcode_in = 7'b0010011; reg_write_in = 1; alu_src_in = 1;
                    if (funct3_in == 3'd1) funct7_in = 7'h00;
                    else if (funct3_in == 3'd5) funct7_in = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                    else funct7_in = 7'($urandom);
                end
                2: begin opcode_in = 7'b0110111; reg_write_in = 1; alu_src_in = 1; end
                3: begin opcode_in = 7'b0010111; reg_write_in = 1; alu_src_in = 1; end
                4: begin opcode_in = 7'b1101111; reg_write_in = 1; jump_in = 1; end
                5: begin opcode_in = 7'b1100111; reg_write_in = 1; jump_in = 1; alu_src_in = 1; funct3_in = 3'd0; end
                6: begin
                    opcode_in = 7'b1100011; branch_in = 1;
                    case ($urandom_range(0, 5))
                        0: funct3_in = 3'd0; 1: funct3_in = 3'd1; 2: funct3_in = 3'd4;
                        3: funct3_in = 3'd5; 4: funct3_in = 3'd6; default: funct3_in = 3'd7;
                    endcase
                end
                7: begin opcode_in = 7'b0000011; reg_write_in = 1; mem_read_in = 1; mem_to_reg_in = 1; alu_src_in = 1; end
                8: begin opcode_in = 7'b0100011; mem_write_in = 1; alu_src_in = 1; end
                9: begin opcode_in = 7'd0; reg_write_in = 1; mem_read_in = 1; jump_in = 1; branch_in = 1; end
                default: begin
                    opcode_in = 7'b0110011; funct7_in = 7'b0000001; reg_write_in = 1;
                    funct3_in = 3'($urandom_range(1, 7));
                end
            endcase
            a  = fwd(rs1_addr_in, rs1_data_in);
            r2 = fwd(rs2_addr_in, rs2_data_in);
            b  = alu_src_in ? imm_in : r2;
            exp_res = 64'd0; res_care = 1; is_bub = 0; taken = 0;
            case (kind)
                0, 1: case (funct3_in)
                    3'd0: exp_res = (kind == 0 && funct7_in[5]) ? a - b : a + b;
                    3'd1: exp_res = a << b[5:0];
                    3'd2: exp_res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                    3'd3: exp_res = (a < b) ? 64'd1 : 64'd0;
                    3'd4: exp_res = a ^ b;
                    3'd5: exp_res = funct7_in[5] ? 64'($signed(a) >>> b[5:0]) : a >> b[5:0];
                    3'd6: exp_res = a | b;
                    default: exp_res = a & b;
                endcase
                2: exp_res = imm_in;
                3: exp_res = pc_in + imm_in;
                4, 5: exp_res = pc_in + 64'd4;
                6: begin
                    res_care = 0;
                    case (funct3_in)
                        3'd0: taken = (a == r2);
                        3'd1: taken = (a != r2);
                        3'd4: taken = ($signed(a) < $signed(r2));
                        3'd5: taken = ($signed(a) >= $signed(r2));
                        3'd6: taken = (a < r2);
                        default: taken = (a >= r2);
                    endcase
                end
                7, 8: exp_res = a + imm_in;
                9: begin is_bub = 1; res_care = 0; end
                default: exp_res = 64'd0;
            endcase
            exp_redir = !mem_stall && ((kind == 6 && taken) || kind == 4 || kind == 5);
            exp_pc = (kind == 5) ? ((a + imm_in) & ~64'd1) : branch_target_in;
            @(negedge clk);
            n_cmp++;
            if ({redirect, ex_busy} !== {exp_redir, 1'b0}) begin
                n_err++; $display("FAIL rnd_redirect #%0d kind %0d: got redirect=%b busy=%b want %b 0",
                                  i, kind, redirect, ex_busy, exp_redir);
            end
            if (exp_redir) begin
                n_cmp++;
                if (redirect_pc !== exp_pc) begin
                    n_err++; $display("FAIL rnd_redirect_pc #%0d: got %h want %h", i, redirect_pc, exp_pc);
                end
            end
            if (!mem_stall) begin
                if (is_bub) model_bubble();
                else begin
                    m_res = exp_res; m_res_care = res_care; m_sd = r2; m_rd = rd_addr_in;
                    m_f3 = funct3_in; m_mr = mem_read_in; m_mw = mem_write_in;
                    m_rw = reg_write_in; m_mtr = mem_to_reg_in; m_data_care = 1;
                end
            end
            @(posedge clk); #1;
            n_cmp++;
            if ({exm_mem_read, exm_mem_write, exm_reg_write, exm_mem_to_reg} !== {m_mr, m_mw, m_rw, m_mtr}) begin
                n_err++; $display("FAIL rnd_ctrl #%0d kind %0d: got %b%b%b%b want %b%b%b%b", i, kind,
                                  exm_mem_read, exm_mem_write, exm_reg_write, exm_mem_to_reg, m_mr, m_mw, m_rw, m_mtr);
            end
            if (m_data_care) begin
                n_cmp++;
                if ({exm_store_data, exm_rd_addr, exm_funct3} !== {m_sd, m_rd, m_f3}) begin
                    n_err++; $display("FAIL rnd_fields #%0d kind %0d: got sd=%h rd=%0d f3=%0d want sd=%h rd=%0d f3=%0d",
                                      i, kind, exm_store_data, exm_rd_addr, exm_funct3, m_sd, m_rd, m_f3);
                end
            end
            if (m_res_care) begin
                n_cmp++;
                if (exm_alu_result !== m_res) begin
                    n_err++; $display("FAIL rnd_result #%0d kind %0d f3 %0d: got %h want %h",
                                      i, kind, funct3_in, exm_alu_result, m_res);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        clear_instr();
        model_bubble();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_forwarding();
        test_branch();
        test_jalr();
        test_mul();
        test_mul_reset();
        test_random_mul(6);
        test_random_alu(300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
